// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: serve timing, scoring, match end and winner reporting.
// Optional ball speed-up on paddle hits is built only when PONG_SPEEDUP_EN is defined.
module pong_game_ctrl #(
    parameter int unsigned WIN_SCORE          = 9,
    parameter int unsigned SERVE_DELAY_FRAMES = 60,
    parameter int unsigned SCORE_W            = 4,
    parameter int unsigned SPEED_W            = 2,
    parameter int unsigned HITS_PER_SPEEDUP   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               miss_left,
    input  logic               miss_right,
    input  logic               paddle_hit,
    output logic               ball_reset,
    output logic               ball_run,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [1:0]         winner,
    output logic [2:0]         state_o,
    output logic [SPEED_W-1:0] ball_speed
);

    localparam int unsigned CntW = $clog2(SERVE_DELAY_FRAMES + 1);
    localparam logic [SCORE_W-1:0] WinVal = SCORE_W'(WIN_SCORE);
    localparam logic [CntW-1:0] DelayVal = CntW'(SERVE_DELAY_FRAMES);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StServe = 3'd1,
        StPlay  = 3'd2,
        StPoint = 3'd3,
        StOver  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               start_q;
    logic [CntW-1:0]    frame_cnt_q, frame_cnt_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic [1:0]         winner_q, winner_d;
    logic               serve_dir_q, serve_dir_d;
    logic               ball_reset_q, ball_reset_d;
    logic               ball_run_q, ball_run_d;
    logic               start_is;

    assign start_is = start_btn & ~start_q;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = '0;  // counter sits at zero outside SERVE, so every entry starts fresh
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        case (state_q)
            StIdle: begin
                if (start_is) state_d = StServe;
            end
            StServe: begin
                frame_cnt_d = frame_cnt_q;
                if (frame_tick) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    if (frame_cnt_d == DelayVal) state_d = StPlay;
                end
            end
            StPlay: begin
                if (miss_left && miss_right) begin
                    serve_dir_d = ~serve_dir_q;
                    state_d     = StPoint;
                end else if (miss_left) begin
                    if (score_r_q != WinVal) score_r_d = score_r_q + 1'b1;
                    serve_dir_d = 1'b0;
                    state_d     = StPoint;
                end else if (miss_right) begin
                    if (score_l_q != WinVal) score_l_d = score_l_q + 1'b1;
                    serve_dir_d = 1'b1;
                    state_d     = StPoint;
                end
            end
            StPoint: begin
                if (score_l_q == WinVal) begin
                    winner_d = 2'b01;
                    state_d  = StOver;
                end else if (score_r_q == WinVal) begin
                    winner_d = 2'b10;
                    state_d  = StOver;
                end else begin
                    state_d = StServe;
                end
            end
            StOver: begin
                if (start_is) begin
                    score_l_d   = '0;
                    score_r_d   = '0;
                    winner_d    = 2'b00;
                    serve_dir_d = 1'b1;
                    state_d     = StServe;
                end
            end
            default: state_d = StIdle;
        endcase
        ball_run_d   = (state_d == StPlay);
        ball_reset_d = (state_d != StPlay);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            start_q      <= 1'b1;
            frame_cnt_q  <= '0;
            score_l_q    <= '0;
            score_r_q    <= '0;
            winner_q     <= 2'b00;
            serve_dir_q  <= 1'b1;
            ball_reset_q <= 1'b1;
            ball_run_q   <= 1'b0;
        end else if (ena) begin
            state_q      <= state_d;
            start_q      <= start_btn;
            frame_cnt_q  <= frame_cnt_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            winner_q     <= winner_d;
            serve_dir_q  <= serve_dir_d;
            ball_reset_q <= ball_reset_d;
            ball_run_q   <= ball_run_d;
        end
    end

`ifdef PONG_SPEEDUP_EN
    localparam int unsigned HitW = (HITS_PER_SPEEDUP > 1) ? $clog2(HITS_PER_SPEEDUP) : 1;

    logic [HitW-1:0]    hit_cnt_q, hit_cnt_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               serve_entry;

    assign serve_entry = (state_d == StServe) && (state_q != StServe);

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        speed_d   = speed_q;
        if (serve_entry) begin
            hit_cnt_d = '0;
            speed_d   = '0;
        end else if (state_q == StPlay && paddle_hit) begin
            if (hit_cnt_q == HitW'(HITS_PER_SPEEDUP - 1)) begin
                hit_cnt_d = '0;
                if (speed_q != '1) speed_d = speed_q + 1'b1;
            end else begin
                hit_cnt_d = hit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
            speed_q   <= '0;
        end else if (ena) begin
            hit_cnt_q <= hit_cnt_d;
            speed_q   <= speed_d;
        end
    end

    assign ball_speed = speed_q;
`else
    logic unused_paddle_hit;
    assign unused_paddle_hit = paddle_hit;
    assign ball_speed        = '0;
`endif

    assign ball_reset = ball_reset_q;
    assign ball_run   = ball_run_q;
    assign serve_dir  = serve_dir_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign winner     = winner_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed vector tables, hand sequences for
// serve timing / match end, and randomized play against a cycle-level game model.
module tb_pong_game_ctrl;

    localparam int WIN   = 9;
    localparam int DELAY = 60;
    localparam int SW    = 4;
    localparam int SPW   = 2;
    localparam int HPS   = 4;

    logic          clk = 1'b0;
    logic          rst_n, ena, frame_tick, start_btn, miss_left, miss_right, paddle_hit;
    logic          ball_reset, ball_run, serve_dir;
    logic [SW-1:0] score_l, score_r;
    logic [1:0]    winner;
    logic [2:0]    state_o;
    logic [SPW-1:0] ball_speed;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .WIN_SCORE          (WIN),
        .SERVE_DELAY_FRAMES (DELAY),
        .SCORE_W            (SW),
        .SPEED_W            (SPW),
        .HITS_PER_SPEEDUP   (HPS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .frame_tick (frame_tick),
        .start_btn  (start_btn),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .paddle_hit (paddle_hit),
        .ball_reset (ball_reset),
        .ball_run   (ball_run),
        .serve_dir  (serve_dir),
        .score_l    (score_l),
        .score_r    (score_r),
        .winner     (winner),
        .state_o    (state_o),
        .ball_speed (ball_speed)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Game model: 0 idle, 1 serving, 2 playing, 3 point scored, 4 match over
    int m_state, m_frames, m_sl, m_sr, m_win, m_dir, m_hits, m_start_prev;

    function automatic void model_reset();
        m_state = 0; m_frames = 0; m_sl = 0; m_sr = 0; m_win = 0;
        m_dir = 1; m_hits = 0; m_start_prev = 1;
    endfunction

    function automatic void begin_serve();
        m_state = 1; m_frames = 0; m_hits = 0;
    endfunction

    function automatic void model_step();
        bit press;
        if (!ena) return;
        press = start_btn && (m_start_prev == 0);
        m_start_prev = start_btn;
        case (m_state)
            0: if (press) begin_serve();
            1: if (frame_tick) begin
                m_frames++;
                if (m_frames == DELAY) m_state = 2;
            end
            2: begin
                if (paddle_hit) m_hits++;
                if (miss_left && miss_right) begin
                    m_dir = 1 - m_dir; m_state = 3;
                end else if (miss_left) begin
                    m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1; m_dir = 0; m_state = 3;
                end else if (miss_right) begin
                    m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1; m_dir = 1; m_state = 3;
                end
            end
            3: if (m_sl == WIN) begin
                m_win = 1; m_state = 4;
            end else if (m_sr == WIN) begin
                m_win = 2; m_state = 4;
            end else begin
                begin_serve();
            end
            default: if (press) begin
                m_sl = 0; m_sr = 0; m_win = 0; m_dir = 1; begin_serve();
            end
        endcase
    endfunction

    function automatic int exp_speed();
`ifdef PONG_SPEEDUP_EN
        int s = m_hits / HPS;
        return (s > (1 << SPW) - 1) ? (1 << SPW) - 1 : s;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] dut_vec();
        return 32'({state_o, ball_reset, ball_run, serve_dir, score_l, score_r, winner, ball_speed});
    endfunction

    function automatic logic [31:0] model_vec();
        return 32'({3'(m_state), m_state != 2, m_state == 2, 1'(m_dir), SW'(m_sl), SW'(m_sr),
                    2'(m_win), SPW'(exp_speed())});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_in(input logic e, input logic ft, input logic st, input logic ml,
                          input logic mr, input logic ph);
        ena = e; frame_tick = ft; start_btn = st; miss_left = ml; miss_right = mr;
        paddle_hit = ph;
    endtask

    task automatic cycle(input string name);
        @(posedge clk);
        model_step();
        #1;
        check(name, dut_vec(), model_vec());
    endtask

    typedef struct {
        logic       en, ft, st, ml, mr;
        logic [2:0] state;
        logic [3:0] sl, sr;
        logic       dir;
        logic [1:0] win;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic en, logic ft, logic st, logic ml, logic mr,
                                logic [2:0] state, logic [3:0] sl, logic [3:0] sr,
                                logic dir, logic [1:0] win);
        vec_t v;
        v.en = en; v.ft = ft; v.st = st; v.ml = ml; v.mr = mr;
        v.state = state; v.sl = sl; v.sr = sr; v.dir = dir; v.win = win;
        return v;
    endfunction

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            set_in(tbl[i].en, tbl[i].ft, tbl[i].st, tbl[i].ml, tbl[i].mr, 1'b0);
            cycle("model");
            check($sformatf("vec%0d", i), 32'({state_o, score_l, score_r, serve_dir, winner}),
                  32'({tbl[i].state, tbl[i].sl, tbl[i].sr, tbl[i].dir, tbl[i].win}));
        end
    endtask

    task automatic go_play();
        for (int i = 0; i < DELAY; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            cycle("serve_wait");
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // start button held across reset release
        tbl.push_back(mk(1, 0, 1, 0, 0, 3'd0, 0, 0, 1, 2'd0));  // 0
        tbl.push_back(mk(1, 0, 1, 0, 0, 3'd0, 0, 0, 1, 2'd0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'd0, 0, 0, 1, 2'd0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3'd0, 0, 0, 1, 2'd0));  // ena low hides the press
        tbl.push_back(mk(1, 0, 1, 0, 0, 3'd1, 0, 0, 1, 2'd0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'd1, 0, 0, 1, 2'd0));  // 5
        tbl.push_back(mk(1, 0, 0, 1, 0, 3'd3, 0, 1, 0, 2'd0));  // 6: miss_left
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'd1, 0, 1, 0, 2'd0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 3'd3, 0, 1, 1, 2'd0));  // 8: double miss toggles
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'd1, 0, 1, 1, 2'd0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3'd2, 0, 1, 1, 2'd0));  // 10: ena low hides miss
        tbl.push_back(mk(1, 0, 0, 0, 1, 3'd3, 1, 1, 1, 2'd0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'd1, 1, 1, 1, 2'd0));  // 12

        rst_n = 1'b0;
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        model_reset();
        #12;
        check("reset", dut_vec(), model_vec());
        @(negedge clk);
        rst_n = 1'b1;

        run_table(0, 5);

        for (int i = 1; i <= DELAY; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            cycle("serve_tick");
            check($sformatf("serve_tick%0d", i), 32'({state_o, ball_run}),
                  (i < DELAY) ? 32'({3'd1, 1'b0}) : 32'({3'd2, 1'b1}));
        end

        run_table(6, 7);
        go_play();
        run_table(8, 9);
        go_play();
        run_table(10, 12);

        // left player runs up to the winning score
        for (int k = 0; k < WIN - 1; k++) begin
            go_play();
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            cycle("drive_l");
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cycle("drive_l_point");
        end
        check("over_state", 32'({state_o, winner, score_l}), 32'({3'd4, 2'b01, 4'(WIN)}));
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("over_miss");
        check("over_miss_ignored", 32'({score_l, score_r}), 32'({4'(WIN), 4'd1}));
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("restart");
        check("restart", 32'({state_o, score_l, score_r, winner, serve_dir}),
              32'({3'd1, 4'd0, 4'd0, 2'b00, 1'b1}));
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("restart_release");

`ifdef PONG_SPEEDUP_EN
        go_play();
        for (int i = 1; i <= 16; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            cycle("hit");
            check($sformatf("speed_after_%0d_hits", i), 32'(ball_speed),
                  32'((i / 4 > 3) ? 3 : i / 4));
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("hit_ena_low");
        check("speed_ena_low", 32'(ball_speed), 32'd3);
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("speed_miss");
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("speed_serve");
        check("speed_cleared", 32'({state_o, ball_speed}), 32'({3'd1, 2'd0}));
`endif

        // asynchronous reset in the middle of a game
        go_play();
        @(posedge clk);
        model_step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset", dut_vec(), model_vec());
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 20000; c++) begin
            ena        = ($urandom_range(0, 7) != 0);
            frame_tick = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
            miss_left  = ($urandom_range(0, 19) == 0);
            miss_right = ($urandom_range(0, 19) == 0);
            paddle_hit = ($urandom_range(0, 3) == 0);
            cycle("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
